// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM encoding and default width.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : serial_arith_pkg

// File: rtl/serial_subtractor_if.sv
// Start/busy/done request bundle for the serial subtractor, operands in and result out.
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_fs_bit_cell.sv
// One-bit full subtractor: d = a - b - bin, bo set when the bit needs a borrow.
module fs_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_c,
    output logic bo_c
);
    always_comb begin
        d_c  = a_i ^ b_i ^ bin_i;
        bo_c = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end
endmodule : fs_bit_cell

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cell_d, cell_bo;

    fs_bit_cell u_cell (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .bin_i (borrow_q),
        .d_c   (cell_d),
        .bo_c  (cell_bo)
    );

    // busy/done are registered copies of the next state so they line up with SHIFT/DONE
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    res_sr_d = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                borrow_d = cell_bo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d       = {cell_d, res_sr_q[WIDTH-1:1]};
                    borrow_out_d = cell_bo;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor that computes A - B one bit per clock, LSB first. It uses a single full-subtractor bit cell and a registered borrow. It is the sequential counterpart to the team's combinational full subtractor: it reuses the same Diff/Borr bit equations, iterated over WIDTH cycles behind a start/busy/done handshake. It is intended as an area-cheap arithmetic unit for slow control paths.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while a subtraction is in progress (SHIFT state)
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  result A - B mod 2^WIDTH; held until the next done
borrow_out  output  1  final borrow; 1 iff A < B (unsigned); held with diff

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; operand shift regs, partial result reg, borrow FF and counter all 0.
- Reset release is synchronous to clk; the first accepted start can occur on the first rising edge after release.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: load a_sr<=a, b_sr<=b, borrow_ff<=0, cnt<=0, res_sr<=0; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT (busy=1), each cycle:
  - Bit cell inputs: A=a_sr[0], B=b_sr[0], Bin=borrow_ff.
  - d = A^B^Bin; bo = (~A&B) | (~(A^B)&Bin).
  - res_sr <= {d, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right with zero fill; borrow_ff <= bo; cnt <= cnt+1.
  - When cnt==WIDTH-1 (the last bit): go to DONE and, on the same edge, load diff <= {d, res_sr[WIDTH-1:1]} and borrow_out <= bo.
- DONE: done=1 for exactly one cycle, busy=0; then unconditionally return to IDLE.
- Latency: start sampled at edge N -> busy high during cycles N+1..N+WIDTH -> done high for cycle N+WIDTH+1. Throughput is one result per WIDTH+2 cycles.
- start while busy or in DONE: ignored, with no effect on the operation in flight. Changes to a/b after the accepting edge have no effect.
- diff and borrow_out change only at the SHIFT->DONE edge. They keep the previous result during a new computation.
- Arithmetic: the result is modulo 2^WIDTH. borrow_out is the borrow out of the MSB, with no sign interpretation. A==B gives diff=0, borrow_out=0.
- Reset asserted mid-operation: aborts immediately, no done pulse, and all outputs return to reset values.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package serial_arith_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One natural sub-module, fs_bit_cell: purely combinational 1-bit full subtractor (a, b, bin -> d, bo) implementing the equations above.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- Reset then a=0x5A, b=0x23, start pulse -> busy for 8 cycles, done on cycle 9 after start, diff=0x37, borrow_out=0.
- a=0x10, b=0x20 -> diff=0xF0, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xC3, b=0xC3 -> diff=0x00, borrow_out=0.
- start a=0x80, b=0x01, then re-pulse start with a=0x00, b=0xFF during busy and at the done cycle -> single done, diff=0x7F, borrow_out=0; no second operation starts.
- Previous result 0x37 held; new op a=0x01, b=0x02 -> diff stays 0x37 throughout busy, becomes 0xFF with borrow_out=1 only at done.
- rst_n low on 4th busy cycle -> busy, done, diff, borrow_out all 0 asynchronously; no done pulse; the next start computes 0x09-0x04=0x05 correctly.
- WIDTH=3 instance: loop i=0..63 with {a,b}=i, start and wait for done each time -> {borrow_out,diff} == a-b (4-bit two's-complement wrap) for all 64 combinations.
